// File: rtl/mips_pkg.sv
// Shared types and constants for the 16-bit MIPS instruction-store logic.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_BYTES = 32;
  localparam logic [15:0] INSTR_NOP = 16'h0000;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Host load port plus datapath fetch/control signals of the instruction store.
interface imem_fetch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int AW     = 4
);
  logic              start;
  logic              load_valid;
  logic              load_ready;
  logic [AW-1:0]     load_addr;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [PC_W-1:0]   instr_pc;
  logic [PC_W-1:0]   pc;
  logic              busy;
  logic              done;
  logic [15:0]       fetch_count;

  modport master (
    output start, load_valid, load_addr, load_data, stall, redirect_valid, redirect_pc,
    input  load_ready, instr_valid, instr, instr_pc, pc, busy, done, fetch_count
  );

  modport slave (
    input  start, load_valid, load_addr, load_data, stall, redirect_valid, redirect_pc,
    output load_ready, instr_valid, instr, instr_pc, pc, busy, done, fetch_count
  );
endinterface

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one combinational read port, no reset.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the PC, loads the instruction RAM from the host and
// streams registered instructions to the datapath until the PC leaves the program window.
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_vld_q, instr_vld_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              pc_out;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_q[AW:1]),
    .rdata_o (ram_rdata)
  );

  assign ram_we = bus.load_valid && bus.load_ready;
  assign pc_out = (pc_q >= PC_W'(IMEM_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (!bus.redirect_valid && !bus.stall && pc_out) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q != RUN);
    bus.busy       = (state_q == RUN);
    bus.done       = (state_q == DONE);
  end

  // Redirect outranks stall; an out-of-window PC ends the run on the next clean cycle.
  always_comb begin
    pc_d        = pc_q;
    instr_pc_d  = instr_pc_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    fcnt_d      = fcnt_q;
    if (state_q != RUN) begin
      if (bus.start) begin
        pc_d        = '0;
        fcnt_d      = '0;
        instr_vld_d = 1'b0;
        instr_d     = INSTR_NOP;
      end
    end else if (bus.redirect_valid) begin
      pc_d        = bus.redirect_pc & ~PC_W'(1);
      instr_vld_d = 1'b0;
      instr_d     = INSTR_NOP;
    end else if (!bus.stall) begin
      if (pc_out) begin
        instr_vld_d = 1'b0;
        instr_d     = INSTR_NOP;
      end else begin
        instr_d     = ram_rdata;
        instr_pc_d  = pc_q;
        instr_vld_d = 1'b1;
        pc_d        = pc_q + PC_W'(2);
        fcnt_d      = sat_inc(fcnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= '0;
      instr_pc_q  <= '0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_pc_q  <= instr_pc_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_vld_q;
  assign bus.fetch_count = fcnt_q;

endmodule
